imem_loader: RTL
================

# imem_loader

Boot-time programming controller for the byte-addressed instruction memory. It accepts a framed byte stream (length, payload, checksum) from a serial receiver and writes the payload byte by byte into the memory's write port, starting at address 0. While a load is in progress it holds the processor in reset, and it reports done or error status to the rest of the system.

## Interface
Parameters:
- ADDR_W, 11: instruction memory byte-address width; capacity DEPTH = 2**ADDR_W = 2048 bytes.
- TIMEOUT, 50000: maximum idle cycles allowed between accepted bytes while loading; must be ≥ 2.

Ports:
- i_clk  in  1  clock; all state changes on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_start  in  1  request to begin a load session; sampled only in IDLE, DONE or ERROR.
- i_rx_valid  in  1  a byte is present on i_rx_data.
- i_rx_data  in  8  stream byte.
- o_rx_ready  out  1  loader can accept a byte this cycle.
- o_mem_we  out  1  byte write strobe to the instruction memory.
- o_mem_addr  out  ADDR_W  write byte address.
- o_mem_wdata  out  8  write byte.
- o_cpu_hold  out  1  holds the processor in reset.
- o_busy  out  1  high while a session is in progress.
- o_done  out  1  last session completed with a correct checksum.
- o_err  out  1  last session failed.
- o_err_code  out  2  failure code: 0 none, 1 bad length, 2 checksum mismatch, 3 timeout.

## Operation
- Frame format: LEN_LO, LEN_HI (16-bit little-endian length L), then L payload bytes, then CSUM. CSUM = sum of the payload bytes mod 256.
- A byte is accepted on any edge where i_rx_valid && o_rx_ready.
- States and transitions:
  - IDLE: i_start → LEN_LO.
  - LEN_LO: on accept, latch the low length byte → LEN_HI.
  - LEN_HI: on accept:
    - L > DEPTH → ERROR, code 1.
    - L == 0 → CSUM.
    - Otherwise → DATA, with address counter = 0 and remaining = L.
  - DATA: on accept:
    - Register a write of the byte at the address counter.
    - Add the byte to the running sum; increment the address; decrement remaining.
    - Last byte (remaining == 1) → CSUM.
  - CSUM: on accept, compare the byte with the running sum: equal → DONE, else → ERROR, code 2.
  - DONE and ERROR: i_start → LEN_LO.
- On entering LEN_LO: running sum, address counter, timeout counter and o_err_code are all cleared.
- o_rx_ready = 1 in LEN_LO, LEN_HI, DATA and CSUM; 0 otherwise.
- o_busy = 1 in the same four states.
- o_cpu_hold: 0 in IDLE and DONE; 1 in LEN_LO, LEN_HI, DATA, CSUM and ERROR.
- o_done = 1 only in DONE; o_err = 1 only in ERROR.
- Timeout:
  - The counter clears on every accepted byte and on entry to LEN_LO, and increments every other cycle in a receiving state.
  - Reaching TIMEOUT−1 without an accept → ERROR, code 3.
  - An accept in the same cycle as the timeout wins.
- i_start is ignored in the receiving states.
- The address counter is ADDR_W bits wide. The L ≤ DEPTH check guarantees it never wraps within a session.
- Memory is never read and no address outside 0..L−1 is written. Memory contents from an aborted session are left as written.
- Reset (including mid-session):
  - State = IDLE; all counters and the running sum = 0.
  - Outputs: o_mem_we=0, o_mem_addr=0, o_mem_wdata=0, o_rx_ready=0, o_cpu_hold=0, o_busy=0, o_done=0, o_err=0, o_err_code=0.
  - Any pending write is dropped.

## Timing
- i_start sampled at edge N → at N+1: state LEN_LO, o_rx_ready=1, o_cpu_hold=1, o_busy=1.
- Throughput: one byte per cycle sustained (o_rx_ready has no bubbles).
- Write latency 1: a payload byte accepted at edge M drives o_mem_we=1, o_mem_addr and o_mem_wdata for the cycle after M. o_mem_we is high exactly one cycle per payload byte.
- CSUM accepted at edge K → at K+1: DONE (o_cpu_hold falls) or ERROR. The final payload write has already been issued before K.
- Back-to-back payload and CSUM bytes are legal. The last write cycle coincides with the first CSUM cycle.
- Length error is flagged at the edge following LEN_HI acceptance. No writes are issued.

## Test plan
- Reset then i_start; stream 04 00 13 05 10 00 28 → four writes at addresses 0..3 with data 13,05,10,00 (one cycle each); DONE; o_done=1; o_cpu_hold 1→0.
- Same frame with CSUM 29 → four writes still occur; ERROR, o_err_code=2, o_cpu_hold stays 1. Then i_start plus a good frame → DONE with code cleared.
- Length 01 08 (2049) → ERROR code 1 after the LEN_HI byte; o_mem_we never asserted. Length 00 00 then CSUM 00 → DONE with no writes.
- With TIMEOUT=16: send 02 00 AA, then hold i_rx_valid=0 → ERROR code 3 after 15 idle cycles. A byte presented on exactly the timeout cycle is accepted instead.
- Full 2048-byte frame with i_rx_valid held high → last write at address 0x7FF, no stall cycles, DONE.
- Assert i_rst mid-DATA → the next cycle shows all outputs 0 and state IDLE; a subsequent i_start begins a fresh frame.

Source files
------------

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: receives a length/payload/checksum byte frame
// and writes the payload into the memory write port while holding the CPU in reset.
module imem_loader #(
    parameter int ADDR_W  = 11,
    parameter int TIMEOUT = 50000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_rx_valid,
    input  logic [7:0]        i_rx_data,
    output logic              o_rx_ready,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [7:0]        o_mem_wdata,
    output logic              o_cpu_hold,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [1:0]        o_err_code
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int REM_W = ADDR_W + 1;
    localparam int TW    = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_DONE, S_ERROR
    } state_t;

    state_t state, state_nx;

    logic [7:0]        len_lo;
    logic [7:0]        sum;
    logic [ADDR_W-1:0] addr;
    logic [REM_W-1:0]  remain;
    logic [TW-1:0]     tcnt;
    logic [1:0]        err_code, err_code_nx;
    logic              receiving, accept, timeout, start_load;
    logic [15:0]       len;

    // write stage registers
    logic              vld_p1;
    logic [ADDR_W-1:0] addr_p1;
    logic [7:0]        wdata_p1;

    function automatic logic [7:0] csum_add(input logic [7:0] a, input logic [7:0] b);
        return a + b;
    endfunction

    assign receiving  = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                        (state == S_DATA)   || (state == S_CSUM);
    assign accept     = i_rx_valid && receiving;
    // the counter would reach TIMEOUT-1 on this edge; an accept on the same edge wins
    assign timeout    = receiving && !accept && (tcnt == TW'(TIMEOUT - 2));
    assign start_load = i_start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));
    assign len        = {i_rx_data, len_lo};

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        err_code_nx = err_code;
        o_rx_ready  = receiving;
        o_busy      = receiving;
        o_cpu_hold  = receiving || (state == S_ERROR);
        o_done      = (state == S_DONE);
        o_err       = (state == S_ERROR);
        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (i_start) begin
                    state_nx    = S_LEN_LO;
                    err_code_nx = 2'd0;
                end
            end
            S_LEN_LO: if (accept) state_nx = S_LEN_HI;
            S_LEN_HI: begin
                if (accept) begin
                    if ({1'b0, len} > 17'(DEPTH)) begin
                        state_nx    = S_ERROR;
                        err_code_nx = 2'd1;
                    end else if (len == 16'd0) begin
                        state_nx = S_CSUM;
                    end else begin
                        state_nx = S_DATA;
                    end
                end
            end
            S_DATA: if (accept && (remain == REM_W'(1))) state_nx = S_CSUM;
            S_CSUM: begin
                if (accept) begin
                    if (i_rx_data == sum) begin
                        state_nx = S_DONE;
                    end else begin
                        state_nx    = S_ERROR;
                        err_code_nx = 2'd2;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
        if (timeout) begin
            state_nx    = S_ERROR;
            err_code_nx = 2'd3;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vld_p1   <= 1'b0;
            addr_p1  <= '0;
            wdata_p1 <= '0;
            len_lo   <= '0;
            sum      <= '0;
            addr     <= '0;
            remain   <= '0;
            tcnt     <= '0;
            err_code <= '0;
        end else begin
            err_code <= err_code_nx;
            vld_p1   <= 1'b0;
            if (start_load) begin
                sum  <= '0;
                addr <= '0;
                tcnt <= '0;
            end else if (receiving) begin
                tcnt <= accept ? '0 : tcnt + TW'(1);
            end
            if (accept) begin
                case (state)
                    S_LEN_LO: len_lo <= i_rx_data;
                    S_LEN_HI: begin
                        remain <= len[REM_W-1:0];
                        addr   <= '0;
                    end
                    S_DATA: begin
                        vld_p1   <= 1'b1;
                        addr_p1  <= addr;
                        wdata_p1 <= i_rx_data;
                        sum      <= csum_add(sum, i_rx_data);
                        addr     <= addr + ADDR_W'(1);
                        remain   <= remain - REM_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_mem_we    = vld_p1;
    assign o_mem_addr  = addr_p1;
    assign o_mem_wdata = wdata_p1;
    assign o_err_code  = err_code;

endmodule
